// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute-stage controller: widths, opcodes,
// FSM state encoding, status-register bit positions and opcode class helpers.
package alu_exec_pkg;

    localparam int WIDTH = 20;
    localparam int HALF  = 10;
    localparam int OPW   = 5;

    // Status register bit positions: sr = {Z, S, C}
    localparam int SR_Z = 2;
    localparam int SR_S = 1;
    localparam int SR_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB2  = 2'd2,
        ST_TRAP = 2'd3
    } state_t;

    localparam logic [OPW-1:0] OP_NOP  = 5'h00;
    localparam logic [OPW-1:0] OP_TRAP = 5'h01;
    localparam logic [OPW-1:0] OP_JMP  = 5'h02;
    localparam logic [OPW-1:0] OP_JZ   = 5'h03;
    localparam logic [OPW-1:0] OP_JS   = 5'h04;
    localparam logic [OPW-1:0] OP_JZS  = 5'h05;
    localparam logic [OPW-1:0] OP_LSR  = 5'h06;
    localparam logic [OPW-1:0] OP_XSR  = 5'h07;
    localparam logic [OPW-1:0] OP_NOT  = 5'h08;
    localparam logic [OPW-1:0] OP_AND  = 5'h09;
    localparam logic [OPW-1:0] OP_OR   = 5'h0A;
    localparam logic [OPW-1:0] OP_XOR  = 5'h0B;
    localparam logic [OPW-1:0] OP_SHR  = 5'h0C;
    localparam logic [OPW-1:0] OP_SHL  = 5'h0D;
    localparam logic [OPW-1:0] OP_ROR  = 5'h0E;
    localparam logic [OPW-1:0] OP_ROL  = 5'h0F;
    localparam logic [OPW-1:0] OP_SWP  = 5'h10;
    localparam logic [OPW-1:0] OP_INC  = 5'h11;
    localparam logic [OPW-1:0] OP_DEC  = 5'h12;
    localparam logic [OPW-1:0] OP_ADD  = 5'h13;
    localparam logic [OPW-1:0] OP_ADC  = 5'h14;
    localparam logic [OPW-1:0] OP_SUB  = 5'h15;
    localparam logic [OPW-1:0] OP_SBC  = 5'h16;
    localparam logic [OPW-1:0] OP_EQ   = 5'h17;
    localparam logic [OPW-1:0] OP_GT   = 5'h18;
    localparam logic [OPW-1:0] OP_LT   = 5'h19;
    localparam logic [OPW-1:0] OP_GE   = 5'h1A;
    localparam logic [OPW-1:0] OP_LE   = 5'h1B;

    // Compute ops occupy a contiguous opcode range and need an ALU cycle
    function automatic logic is_compute(input logic [OPW-1:0] op);
        return (op >= OP_NOT) && (op <= OP_LE);
    endfunction

    // Everything above the last defined compute op is illegal
    function automatic logic is_illegal(input logic [OPW-1:0] op);
        return op > OP_LE;
    endfunction

endpackage

// File: rtl/alu_flag_upd.sv
// Opcode class decode: which compute ops write back and which flags they touch.
module alu_flag_upd
    import alu_exec_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output logic           has_wb,
    output logic           upd_z,
    output logic           upd_s,
    output logic           upd_c
);

    // Map each compute opcode onto its writeback / flag-update class
    always_comb begin
        has_wb = 1'b0;
        upd_z  = 1'b0;
        upd_s  = 1'b0;
        upd_c  = 1'b0;
        case (opcode)
            OP_NOT, OP_AND, OP_OR, OP_XOR: begin
                has_wb = 1'b1;
                upd_z  = 1'b1;
            end
            OP_SHR, OP_SHL, OP_INC, OP_DEC,
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                has_wb = 1'b1;
                upd_z  = 1'b1;
                upd_c  = 1'b1;
            end
            OP_EQ: begin
                upd_z = 1'b1;
            end
            OP_GT, OP_LT: begin
                upd_s = 1'b1;
            end
            OP_GE, OP_LE: begin
                upd_s = 1'b1;
                upd_z = 1'b1;
            end
            OP_ROR, OP_ROL, OP_SWP: begin
                has_wb = 1'b1;
            end
            default: begin
                has_wb = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: accepts one decoded op at a time, drives the ALU,
// captures results/flags, issues writebacks and resolves program-flow ops.
module alu_exec_ctrl
    import alu_exec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_mode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_c,
    input  logic [WIDTH-1:0] alu_c2,
    input  logic             alu_zero,
    input  logic             alu_sign,
    input  logic             alu_carry,
    output logic             wb_valid,
    output logic             wb_dst,
    output logic [WIDTH-1:0] wb_data,
    output logic             jump_taken,
    output logic [WIDTH-1:0] jump_addr,
    output logic [2:0]       sr,
    output logic             trap
);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             has_wb;
    logic             upd_z;
    logic             upd_s;
    logic             upd_c;

    logic             nxt_op_ready;
    logic [OPW-1:0]   nxt_alu_op;
    logic             nxt_alu_mode;
    logic [WIDTH-1:0] nxt_alu_a;
    logic [WIDTH-1:0] nxt_alu_b;
    logic             nxt_wb_valid;
    logic             nxt_wb_dst;
    logic [WIDTH-1:0] nxt_wb_data;
    logic             nxt_jump_taken;
    logic [WIDTH-1:0] nxt_jump_addr;
    logic [2:0]       nxt_sr;
    logic             nxt_trap;

    assign accept  = op_valid & op_ready;
    assign alu_cin = sr[SR_C];

    // Class decode runs on the registered opcode the ALU is executing
    alu_flag_upd u_flag_upd (
        .opcode (alu_op),
        .has_wb (has_wb),
        .upd_z  (upd_z),
        .upd_s  (upd_s),
        .upd_c  (upd_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_compute(opcode)) begin
                        next_state = ST_EXEC;
                    end else if ((opcode == OP_TRAP) || is_illegal(opcode)) begin
                        next_state = ST_TRAP;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (alu_op == OP_SWP) begin
                    next_state = ST_WB2;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_WB2:  next_state = ST_IDLE;
            ST_TRAP: next_state = ST_TRAP;
            default: next_state = ST_IDLE;
        endcase
    end

    // Next values of all registered outputs
    always_comb begin
        nxt_alu_op     = alu_op;
        nxt_alu_mode   = alu_mode;
        nxt_alu_a      = alu_a;
        nxt_alu_b      = alu_b;
        nxt_wb_valid   = 1'b0;
        nxt_wb_dst     = 1'b0;
        nxt_wb_data    = wb_data;
        nxt_jump_taken = 1'b0;
        nxt_jump_addr  = jump_addr;
        nxt_sr         = sr;
        nxt_trap       = (next_state == ST_TRAP);
        // A swap keeps ready low until its second writeback has left the bus
        nxt_op_ready   = (next_state == ST_IDLE) && (state != ST_WB2);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nxt_alu_op   = opcode;
                    nxt_alu_mode = mode;
                    nxt_alu_a    = a;
                    nxt_alu_b    = b;
                    case (opcode)
                        OP_JMP: begin
                            nxt_jump_taken = 1'b1;
                            nxt_jump_addr  = a;
                        end
                        OP_JZ: begin
                            if (sr[SR_Z]) begin
                                nxt_jump_taken = 1'b1;
                                nxt_jump_addr  = a;
                            end else begin
                                nxt_jump_taken = 1'b0;
                            end
                        end
                        OP_JS: begin
                            if (sr[SR_S]) begin
                                nxt_jump_taken = 1'b1;
                                nxt_jump_addr  = a;
                            end else begin
                                nxt_jump_taken = 1'b0;
                            end
                        end
                        OP_JZS: begin
                            if (sr[SR_Z] | sr[SR_S]) begin
                                nxt_jump_taken = 1'b1;
                                nxt_jump_addr  = a;
                            end else begin
                                nxt_jump_taken = 1'b0;
                            end
                        end
                        OP_LSR:  nxt_sr = a[2:0];
                        OP_XSR:  nxt_sr = sr ^ a[2:0];
                        default: nxt_sr = sr;
                    endcase
                end else begin
                    nxt_jump_taken = 1'b0;
                end
            end
            ST_EXEC: begin
                if (has_wb) begin
                    nxt_wb_valid = 1'b1;
                    nxt_wb_dst   = 1'b0;
                    nxt_wb_data  = alu_c;
                end else begin
                    nxt_wb_valid = 1'b0;
                end
                if (upd_z) begin
                    nxt_sr[SR_Z] = alu_zero;
                end else begin
                    nxt_sr[SR_Z] = sr[SR_Z];
                end
                if (upd_s) begin
                    nxt_sr[SR_S] = alu_sign;
                end else begin
                    nxt_sr[SR_S] = sr[SR_S];
                end
                if (upd_c) begin
                    nxt_sr[SR_C] = alu_carry;
                end else begin
                    nxt_sr[SR_C] = sr[SR_C];
                end
            end
            ST_WB2: begin
                nxt_wb_valid = 1'b1;
                nxt_wb_dst   = 1'b1;
                nxt_wb_data  = alu_c2;
            end
            ST_TRAP: begin
                nxt_wb_valid = 1'b0;
            end
            default: begin
                nxt_wb_valid = 1'b0;
            end
        endcase
    end

    // Output registers; reset clears everything, discarding pending strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_ready   <= 1'b0;
            alu_op     <= 5'h00;
            alu_mode   <= 1'b0;
            alu_a      <= 20'h00000;
            alu_b      <= 20'h00000;
            wb_valid   <= 1'b0;
            wb_dst     <= 1'b0;
            wb_data    <= 20'h00000;
            jump_taken <= 1'b0;
            jump_addr  <= 20'h00000;
            sr         <= 3'b000;
            trap       <= 1'b0;
        end else begin
            op_ready   <= nxt_op_ready;
            alu_op     <= nxt_alu_op;
            alu_mode   <= nxt_alu_mode;
            alu_a      <= nxt_alu_a;
            alu_b      <= nxt_alu_b;
            wb_valid   <= nxt_wb_valid;
            wb_dst     <= nxt_wb_dst;
            wb_data    <= nxt_wb_data;
            jump_taken <= nxt_jump_taken;
            jump_addr  <= nxt_jump_addr;
            sr         <= nxt_sr;
            trap       <= nxt_trap;
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed self-checking bench for alu_exec_ctrl; the bench plays the ALU.
module tb_alu_exec_ctrl;

    localparam logic [4:0] C_TRAP = 5'h01;
    localparam logic [4:0] C_JMP  = 5'h02;
    localparam logic [4:0] C_JZ   = 5'h03;
    localparam logic [4:0] C_JS   = 5'h04;
    localparam logic [4:0] C_LSR  = 5'h06;
    localparam logic [4:0] C_XSR  = 5'h07;
    localparam logic [4:0] C_SWP  = 5'h10;
    localparam logic [4:0] C_ADD  = 5'h13;
    localparam logic [4:0] C_ADC  = 5'h14;
    localparam logic [4:0] C_SUB  = 5'h15;
    localparam logic [4:0] C_GE   = 5'h1A;
    localparam logic [4:0] C_ILL  = 5'h1E;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [4:0]  opcode;
    logic        mode;
    logic [19:0] a;
    logic [19:0] b;
    logic [4:0]  alu_op;
    logic        alu_mode;
    logic [19:0] alu_a;
    logic [19:0] alu_b;
    logic        alu_cin;
    logic [19:0] alu_c;
    logic [19:0] alu_c2;
    logic        alu_zero;
    logic        alu_sign;
    logic        alu_carry;
    logic        wb_valid;
    logic        wb_dst;
    logic [19:0] wb_data;
    logic        jump_taken;
    logic [19:0] jump_addr;
    logic [2:0]  sr;
    logic        trap;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .opcode     (opcode),
        .mode       (mode),
        .a          (a),
        .b          (b),
        .alu_op     (alu_op),
        .alu_mode   (alu_mode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_c      (alu_c),
        .alu_c2     (alu_c2),
        .alu_zero   (alu_zero),
        .alu_sign   (alu_sign),
        .alu_carry  (alu_carry),
        .wb_valid   (wb_valid),
        .wb_dst     (wb_dst),
        .wb_data    (wb_data),
        .jump_taken (jump_taken),
        .jump_addr  (jump_addr),
        .sr         (sr),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one op for exactly one accepting edge
    task automatic issue(input logic [4:0] op, input logic md, input logic [19:0] va, input logic [19:0] vb);
        chk_val("ready_before_issue", {31'd0, op_ready}, 32'd1);
        op_valid = 1'b1;
        opcode   = op;
        mode     = md;
        a        = va;
        b        = vb;
        step();
        op_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; opcode = 5'h00; mode = 1'b0;
        a = 20'h0; b = 20'h0; alu_c = 20'h0; alu_c2 = 20'h0;
        alu_zero = 1'b0; alu_sign = 1'b0; alu_carry = 1'b0;

        // reset state
        step();
        step();
        chk_val("rst_ready", {31'd0, op_ready}, 32'd0);
        chk_val("rst_sr", {29'd0, sr}, 32'd0);
        chk_val("rst_trap", {31'd0, trap}, 32'd0);
        chk_val("rst_wb", {31'd0, wb_valid}, 32'd0);
        rst = 1'b0;
        chk_val("ready_before_edge", {31'd0, op_ready}, 32'd0);
        step();
        chk_val("ready_after_rel", {31'd0, op_ready}, 32'd1);

        // ADD 5+3, full word
        alu_c = 20'h00008; alu_zero = 1'b0; alu_sign = 1'b0; alu_carry = 1'b0;
        issue(C_ADD, 1'b1, 20'h00005, 20'h00003);
        chk_val("add_alu_op", {27'd0, alu_op}, {27'd0, C_ADD});
        chk_val("add_alu_a", {12'd0, alu_a}, 32'h5);
        chk_val("add_alu_b", {12'd0, alu_b}, 32'h3);
        chk_val("add_alu_mode", {31'd0, alu_mode}, 32'd1);
        chk_val("add_exec_ready", {31'd0, op_ready}, 32'd0);
        chk_val("add_exec_wb", {31'd0, wb_valid}, 32'd0);
        step();
        chk_val("add_wb", {31'd0, wb_valid}, 32'd1);
        chk_val("add_dst", {31'd0, wb_dst}, 32'd0);
        chk_val("add_data", {12'd0, wb_data}, 32'h8);
        chk_val("add_sr", {29'd0, sr}, 32'd0);
        chk_val("add_ready_back", {31'd0, op_ready}, 32'd1);

        // SUB with zero result, then JZ taken
        alu_c = 20'h00000; alu_zero = 1'b1; alu_carry = 1'b0;
        issue(C_SUB, 1'b1, 20'h00009, 20'h00009);
        step();
        chk_val("sub_data", {12'd0, wb_data}, 32'h0);
        chk_val("sub_sr", {29'd0, sr}, 32'b100);
        issue(C_JZ, 1'b1, 20'h00123, 20'h00000);
        chk_val("jz_taken", {31'd0, jump_taken}, 32'd1);
        chk_val("jz_addr", {12'd0, jump_addr}, 32'h00123);
        chk_val("jz_no_wb", {31'd0, wb_valid}, 32'd0);
        // JS not taken (S=0): no strobe, address held
        issue(C_JS, 1'b1, 20'h00456, 20'h00000);
        chk_val("js_not_taken", {31'd0, jump_taken}, 32'd0);
        chk_val("js_addr_held", {12'd0, jump_addr}, 32'h00123);
        issue(C_JMP, 1'b1, 20'hABCDE, 20'h00000);
        chk_val("jmp_taken", {31'd0, jump_taken}, 32'd1);
        chk_val("jmp_addr", {12'd0, jump_addr}, 32'hABCDE);
        step();
        chk_val("jmp_strobe_drop", {31'd0, jump_taken}, 32'd0);

        // SWP: two writebacks, ready low three cycles, no flag change
        alu_c = 20'hAAAAA; alu_c2 = 20'h55555; alu_zero = 1'b0; alu_carry = 1'b1;
        issue(C_SWP, 1'b1, 20'h11111, 20'h22222);
        chk_val("swp_ready1", {31'd0, op_ready}, 32'd0);
        step();
        chk_val("swp_wb1", {31'd0, wb_valid}, 32'd1);
        chk_val("swp_dst1", {31'd0, wb_dst}, 32'd0);
        chk_val("swp_data1", {12'd0, wb_data}, 32'hAAAAA);
        chk_val("swp_ready2", {31'd0, op_ready}, 32'd0);
        step();
        chk_val("swp_wb2", {31'd0, wb_valid}, 32'd1);
        chk_val("swp_dst2", {31'd0, wb_dst}, 32'd1);
        chk_val("swp_data2", {12'd0, wb_data}, 32'h55555);
        chk_val("swp_ready3", {31'd0, op_ready}, 32'd0);
        step();
        chk_val("swp_wb_end", {31'd0, wb_valid}, 32'd0);
        chk_val("swp_ready_back", {31'd0, op_ready}, 32'd1);
        chk_val("swp_sr", {29'd0, sr}, 32'b100);

        // LSR / XSR / ADC carry-in
        issue(C_LSR, 1'b1, 20'h00007, 20'h00000);
        chk_val("lsr_sr", {29'd0, sr}, 32'b111);
        chk_val("lsr_cin", {31'd0, alu_cin}, 32'd1);
        issue(C_XSR, 1'b1, 20'h00005, 20'h00000);
        chk_val("xsr_sr", {29'd0, sr}, 32'b010);
        alu_c = 20'h00010; alu_zero = 1'b0; alu_sign = 1'b0; alu_carry = 1'b1;
        issue(C_ADC, 1'b1, 20'h00008, 20'h00008);
        chk_val("adc_cin", {31'd0, alu_cin}, 32'd0);
        step();
        chk_val("adc_data", {12'd0, wb_data}, 32'h10);
        chk_val("adc_sr", {29'd0, sr}, 32'b011);

        // GE: S and Z updated, C kept, no writeback
        alu_zero = 1'b0; alu_sign = 1'b0; alu_carry = 1'b0;
        issue(C_GE, 1'b1, 20'h00002, 20'h00001);
        step();
        chk_val("ge_no_wb", {31'd0, wb_valid}, 32'd0);
        chk_val("ge_sr", {29'd0, sr}, 32'b001);

        // Half-word mode passes through unmasked
        alu_c = 20'h003FF; alu_zero = 1'b0; alu_carry = 1'b0;
        issue(C_ADD, 1'b0, 20'hFFFFF, 20'h12345);
        chk_val("half_mode", {31'd0, alu_mode}, 32'd0);
        chk_val("half_a", {12'd0, alu_a}, 32'hFFFFF);
        chk_val("half_b", {12'd0, alu_b}, 32'h12345);
        step();
        chk_val("half_data", {12'd0, wb_data}, 32'h003FF);
        chk_val("half_sr", {29'd0, sr}, 32'b000);

        // LSR then illegal opcode: trap, sr untouched, absorbing
        issue(C_LSR, 1'b1, 20'h00005, 20'h00000);
        issue(C_ILL, 1'b1, 20'h00007, 20'h00000);
        op_valid = 1'b1;
        opcode   = C_ADD;
        for (int i = 0; i < 20; i++) begin
            chk_val("trap_flag", {31'd0, trap}, 32'd1);
            chk_val("trap_ready", {31'd0, op_ready}, 32'd0);
            step();
        end
        chk_val("trap_sr", {29'd0, sr}, 32'b101);
        chk_val("trap_no_wb", {31'd0, wb_valid}, 32'd0);
        op_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_val("trap_rst_trap", {31'd0, trap}, 32'd0);
        chk_val("trap_rst_sr", {29'd0, sr}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk_val("post_trap_ready", {31'd0, op_ready}, 32'd1);

        // TRAP opcode also halts
        issue(C_TRAP, 1'b1, 20'h00000, 20'h00000);
        chk_val("trapop_flag", {31'd0, trap}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Reset during WB2 of a swap discards the second writeback
        alu_c = 20'h0F0F0; alu_c2 = 20'h0A0A0;
        issue(C_SWP, 1'b1, 20'h00001, 20'h00002);
        step();
        chk_val("swprst_wb1", {31'd0, wb_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_val("swprst_wb_drop", {31'd0, wb_valid}, 32'd0);
        chk_val("swprst_ready", {31'd0, op_ready}, 32'd0);
        step();
        chk_val("swprst_no_wb2", {31'd0, wb_valid}, 32'd0);
        rst = 1'b0;
        step();
        chk_val("swprst_ready_back", {31'd0, op_ready}, 32'd1);
        chk_val("swprst_no_wb_after", {31'd0, wb_valid}, 32'd0);
        step();
        chk_val("swprst_still_quiet", {31'd0, wb_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute-stage controller that sequences the 20-bit ALU for one instruction at a time.
- Accepts decoded ops over a valid/ready handshake and drives the ALU operand, opcode and mode lines.
- Samples the ALU results and flags, owns the 3-bit status register (Z, S, C), and issues register writebacks.
- Resolves program-flow ops (jumps, status-register loads, trap).

Parameters:
- WIDTH, 20, datapath word width.
- HALF, 10, half-word width; used when mode=0.
- OPW, 5, opcode width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  a decoded op is present.
- op_ready  out  1  controller can accept an op.
- opcode  in  OPW  operation code (encoding in the package).
- mode  in  1  1 = full-word, 0 = half-word.
- a  in  WIDTH  operand A; also the jump target and the LSR/XSR source.
- b  in  WIDTH  operand B.
- alu_op  out  OPW  opcode presented to the ALU.
- alu_mode  out  1  mode presented to the ALU.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_cin  out  1  carry-in to the ALU; equals sr[0].
- alu_c  in  WIDTH  primary ALU result (out_a for swap).
- alu_c2  in  WIDTH  secondary ALU result (out_b for swap).
- alu_zero  in  1  ALU zero flag.
- alu_sign  in  1  ALU sign flag.
- alu_carry  in  1  ALU carry flag.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_dst  out  1  writeback destination: 0 = register A, 1 = register B.
- wb_data  out  WIDTH  writeback value.
- jump_taken  out  1  one-cycle strobe when a jump is taken.
- jump_addr  out  WIDTH  jump target address.
- sr  out  3  status register {Z, S, C}; sr[2]=Z, sr[1]=S, sr[0]=C.
- trap  out  1  controller is halted in trap mode.

Behaviour:
- Reset: all outputs 0; sr=3'b000; state IDLE. Because op_ready is an output, it is also 0 while rst is held, and rises to 1 on the first clock edge after rst deasserts.
- States:
  - IDLE: op_ready=1.
  - EXEC: ALU inputs held stable.
  - WB2: second writeback of a swap.
  - TRAP: absorbing.
- Handshake: an op is accepted on an edge where op_valid & op_ready. op_ready=0 in every state except IDLE.
- On acceptance, opcode/mode/a/b are registered onto alu_op/alu_mode/alu_a/alu_b. Compute ops go to EXEC; flow ops complete directly, returning to IDLE.
- EXEC lasts 1 cycle. At its closing edge the controller:
  - registers wb_valid=1, wb_dst=0, wb_data=alu_c, where the opcode produces a result;
  - updates flags per the class rules below;
  - goes to IDLE, or to WB2 for SWP.
- Latency: accept at edge k; wb_valid high during cycle k+2; next accept possible at edge k+2.
- WB2: wb_valid=1, wb_dst=1, wb_data=alu_c2 for one cycle, then IDLE.
- Flag update classes (flags not listed are unchanged):
  - NOT/AND/OR/XOR: Z.
  - SHR/SHL/INC/DEC/ADD/ADC/SUB/SBC: Z and C.
  - EQ: Z only, no writeback.
  - GT/LT: S only, no writeback.
  - GE/LE: S and Z, no writeback.
  - ROR/ROL/SWP: no flags.
- Half-word mode: the ALU handles width. The controller passes mode through and does not mask.
- Flow ops (no ALU cycle, result on the cycle after acceptance):
  - NOP: nothing.
  - JMP: jump_taken=1, jump_addr=a.
  - JZ: jump taken if Z=1.
  - JS: jump taken if S=1.
  - JZS: jump taken if Z|S.
  - A not-taken jump produces no strobe.
  - LSR: sr <= a[2:0].
  - XSR: sr <= sr ^ a[2:0].
  - TRAP: enter TRAP.
- Illegal opcodes 0x1C–0x1F enter TRAP and leave sr unchanged.
- TRAP: trap=1, op_ready=0; exits only on rst.
- Reset mid-operation: any pending writeback or WB2 is discarded; no strobe is emitted after rst asserts.
- jump_taken and wb_valid never assert in the same cycle.

Decomposition:
- Package alu_exec_pkg holds:
  - opcode constants: NOP=0x00, TRAP=0x01, JMP=0x02, JZ=0x03, JS=0x04, JZS=0x05, LSR=0x06, XSR=0x07, NOT=0x08, AND=0x09, OR=0x0A, XOR=0x0B, SHR=0x0C, SHL=0x0D, ROR=0x0E, ROL=0x0F, SWP=0x10, INC=0x11, DEC=0x12, ADD=0x13, ADC=0x14, SUB=0x15, SBC=0x16, EQ=0x17, GT=0x18, LT=0x19, GE=0x1A, LE=0x1B;
  - state encodings;
  - SR bit indices.
- One natural sub-module, alu_flag_upd: combinational class decode mapping opcode to {has_wb, upd_z, upd_s, upd_c}.

Test Plan:
- ADD, mode=1, a=5, b=3, ALU returns c=8, zero=0, carry=0 -> wb_valid at k+2, wb_dst=0, wb_data=8, sr=000.
- SUB with ALU zero=1, then JZ a=0x00123 -> sr[2]=1, then jump_taken=1, jump_addr=0x00123, no wb_valid.
- SWP, ALU c=0xAAAAA, c2=0x55555 -> two consecutive wb cycles: (dst 0, 0xAAAAA) then (dst 1, 0x55555); op_ready low for 3 cycles.
- LSR a=0x00007, then XSR a=0x00005 -> sr=111, then sr=010; ADC then drives alu_cin=0.
- Opcode 0x1E -> trap=1, op_ready=0 for 20 cycles with op_valid held high; rst -> trap=0, sr=000.
- rst asserted during WB2 of a swap -> wb_valid drops immediately, no second strobe; op_ready=1 on the first edge after rst release.
